// File: rtl/riscv_base_div.sv
// rtl/riscv_base_div.sv - iterative restoring RV32M divider (DIV/DIVU/REM/REMU)
module riscv_base_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic               op_rem_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               quo_neg_q;
    logic               rem_neg_q;

    logic               is_signed;
    logic               div_zero;
    logic               overflow;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last_step;

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        is_signed = ~req_op_i[0];
        div_zero  = (req_b_i == '0);
        overflow  = is_signed && (req_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (req_b_i == '1);
        a_abs     = (is_signed && req_a_i[WIDTH-1]) ? -req_a_i : req_a_i;
        b_abs     = (is_signed && req_b_i[WIDTH-1]) ? -req_b_i : req_b_i;

        // Partial remainder shifted left can exceed WIDTH bits for large unsigned divisors.
        trial     = {rem_q, quo_q[WIDTH-1]};
        ge        = (trial >= {1'b0, dvs_q});
        diff      = trial[WIDTH-1:0] - dvs_q;
        rem_nxt   = ge ? diff : trial[WIDTH-1:0];
        quo_nxt   = {quo_q[WIDTH-2:0], ge};
        quo_fix   = quo_neg_q ? -quo_nxt : quo_nxt;
        rem_fix   = rem_neg_q ? -rem_nxt : rem_nxt;
        last_step = (cnt_q == CNT_W'(WIDTH-1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_rem_q    <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            res_valid_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_rem_q <= req_op_i[1];
                        if (div_zero) begin
                            res_data_o  <= req_op_i[1] ? req_a_i : '1;
                            res_valid_o <= 1'b1;
                            state_q     <= DONE;
                        end else if (overflow) begin
                            res_data_o  <= req_op_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                            res_valid_o <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            quo_q     <= a_abs;
                            dvs_q     <= b_abs;
                            rem_q     <= '0;
                            cnt_q     <= '0;
                            quo_neg_q <= is_signed & (req_a_i[WIDTH-1] ^ req_b_i[WIDTH-1]);
                            rem_neg_q <= is_signed & req_a_i[WIDTH-1];
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        res_data_o  <= op_rem_q ? rem_fix : quo_fix;
                        res_valid_o <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_base_div.sv
// tb/tb_riscv_base_div.sv - scoreboard bench for riscv_base_div
module tb_riscv_base_div;

    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        busy;

    always #5 clk = ~clk;

    riscv_base_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .busy_o      (busy)
    );

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   rand_bp = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // RISC-V M semantics evaluated with 64-bit arithmetic so -2^31/-1 needs no special handling.
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_v, ua, ub;
        sa = longint'($signed(a));
        sb_v = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            DIV:     return 32'(sa / sb_v);
            DIVU:    return 32'(ua / ub);
            REM:     return 32'(sa % sb_v);
            default: return 32'(ua % ub);
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (res_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", res_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_data", res_data, e.data);
                    check("result_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
            prev_valid <= res_valid;
        end
    end

    always @(negedge clk) if (rand_bp) res_ready <= ($urandom_range(0, 3) != 0);

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        if (push) sb.push_back('{ref_model(op, a, b), cyc + 1, exp_lat(op, a, b)});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 2'($urandom);
        req_a = $urandom;
        req_b = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            total_cnt++;
            $display("FAIL drain_timeout: queue=%0d busy=%0b required queue=0 busy=0", sb.size(), busy);
        end
    endtask

    initial begin
        int n;
        int vc;
        logic [1:0]  op;
        logic [31:0] a, b;

        #12;
        check("reset_valid", res_valid, 1'b0);
        check("reset_data", res_data, 32'd0);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(DIVU, 32'd100, 32'd7, 1);
        issue(REMU, 32'd100, 32'd7, 1);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1);
        issue(REM, 32'hFFFF_FFF9, 32'd2, 1);
        issue(REM, 32'd7, 32'hFFFF_FFFE, 1);
        issue(DIVU, 32'd5, 32'd0, 1);
        issue(REMU, 32'd5, 32'd0, 1);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(DIVU, 32'hFFFF_FFFF, 32'd1, 1);
        issue(REMU, 32'hFFFF_FFFF, 32'h10, 1);
        drain();

        res_ready = 1'b0;
        issue(DIVU, 32'd1000, 32'd9, 1);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", res_valid, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("bp_data_stable", res_data, 32'd111);
        end
        check("bp_req_ready", req_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_retire_valid", res_valid, 1'b0);
        check("bp_retire_ready", req_ready, 1'b1);
        issue(REMU, 32'd1000, 32'd9, 1);
        check("accept_after_bp", busy, 1'b1);
        drain();

        issue(DIVU, 32'd100, 32'd7, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        req_op = DIVU;
        req_a = 32'd50;
        req_b = 32'd0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush_idle", busy, 1'b0);
        check("flush_valid", res_valid, 1'b0);
        vc = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid || busy) vc++;
        end
        check("flush_no_result", 32'(vc), 32'd0);

        issue(DIVU, 32'd100, 32'd7, 1);
        drain();
        issue(DIVU, 32'd100, 32'd7, 0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", res_valid, 1'b0);
        check("async_rst_data", res_data, 32'd0);
        check("async_rst_ready", req_ready, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(op, a, b, 1);
        end
        drain();
        rand_bp = 1'b0;
        res_ready = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
